// File: rtl/regfile_wb_arbiter_if.sv
// Valid/ready writeback request channel: one requester into one holding slot.
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              valid;
    logic [4:0]        addr;
    logic [DATA_W-1:0] data;
    logic              ready;

    modport master (output valid, output addr, output data, input ready);
    modport slave  (input valid, input addr, input data, output ready);
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-requester register-file writeback arbiter with one-entry slots,
// starvation protection, same-address ordering and a pending-write mask.
module regfile_wb_arbiter #(
    parameter int STARVE_LIMIT = 3,
    parameter int DATA_W       = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wb_arbiter_if.slave  ex,
    regfile_wb_arbiter_if.slave  mem,
    output logic                 wen,
    output logic [4:0]           write_addr,
    output logic [DATA_W-1:0]    write_data,
    output logic [31:0]          pending_mask
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic              s0_v_q, s0_v_d, s1_v_q, s1_v_d;
    logic [4:0]        s0_a_q, s0_a_d, s1_a_q, s1_a_d;
    logic [DATA_W-1:0] s0_dat_q, s0_dat_d, s1_dat_q, s1_dat_d;
    logic              age_q, age_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wen_q, wen_d;
    logic [4:0]        wa_q, wa_d;
    logic [DATA_W-1:0] wd_q, wd_d;

    logic g0, g1, acc0, acc1, both, same_addr;
    logic [31:0] pm;

    assign both      = s0_v_q && s1_v_q;
    assign same_addr = (s0_a_q == s1_a_q);

    // age_q = 1 means slot 0 was loaded before slot 1
    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        unique case (1'b1)
            (s0_v_q && !s1_v_q): g0 = 1'b1;
            (!s0_v_q && s1_v_q): g1 = 1'b1;
            (both && same_addr): begin
                g0 = age_q;
                g1 = !age_q;
            end
            (both && !same_addr): begin
                g1 = (cnt_q == LIMIT);
                g0 = (cnt_q != LIMIT);
            end
            default: ;
        endcase
    end

    assign ex.ready  = !s0_v_q || g0;
    assign mem.ready = !s1_v_q || g1;
    assign acc0      = ex.valid && ex.ready;
    assign acc1      = mem.valid && mem.ready;

    always_comb begin
        s0_v_d   = s0_v_q && !g0;
        s0_a_d   = s0_a_q;
        s0_dat_d = s0_dat_q;
        s1_v_d   = s1_v_q && !g1;
        s1_a_d   = s1_a_q;
        s1_dat_d = s1_dat_q;
        if (acc0) begin
            s0_v_d   = 1'b1;
            s0_a_d   = ex.addr;
            s0_dat_d = ex.data;
        end
        if (acc1) begin
            s1_v_d   = 1'b1;
            s1_a_d   = mem.addr;
            s1_dat_d = mem.data;
        end
        // a freshly loaded slot is always the younger one; a tie favours slot 1
        age_d = age_q;
        if (acc0)
            age_d = 1'b0;
        else if (acc1)
            age_d = 1'b1;
    end

    always_comb begin
        cnt_d = 4'd0;
        if (s1_v_q && !g1)
            cnt_d = (cnt_q == LIMIT) ? LIMIT : cnt_q + 4'd1;
    end

    always_comb begin
        wen_d = 1'b0;
        wa_d  = wa_q;
        wd_d  = wd_q;
        if (g0) begin
            wen_d = (s0_a_q != 5'd0);
            wa_d  = s0_a_q;
            wd_d  = s0_dat_q;
        end else if (g1) begin
            wen_d = (s1_a_q != 5'd0);
            wa_d  = s1_a_q;
            wd_d  = s1_dat_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s0_v_q   <= 1'b0;
            s0_a_q   <= 5'd0;
            s0_dat_q <= '0;
            s1_v_q   <= 1'b0;
            s1_a_q   <= 5'd0;
            s1_dat_q <= '0;
            age_q    <= 1'b0;
            cnt_q    <= 4'd0;
            wen_q    <= 1'b0;
            wa_q     <= 5'd0;
            wd_q     <= '0;
        end else begin
            s0_v_q   <= s0_v_d;
            s0_a_q   <= s0_a_d;
            s0_dat_q <= s0_dat_d;
            s1_v_q   <= s1_v_d;
            s1_a_q   <= s1_a_d;
            s1_dat_q <= s1_dat_d;
            age_q    <= age_d;
            cnt_q    <= cnt_d;
            wen_q    <= wen_d;
            wa_q     <= wa_d;
            wd_q     <= wd_d;
        end
    end

    always_comb begin
        pm = 32'd0;
        if (s0_v_q)
            pm[s0_a_q] = 1'b1;
        if (s1_v_q)
            pm[s1_a_q] = 1'b1;
        if (wen_q)
            pm[wa_q] = 1'b1;
        pm[0] = 1'b0;
    end

    assign pending_mask = pm;
    assign wen          = wen_q;
    assign write_addr   = wa_q;
    assign write_data   = wd_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, hand sequences for
// starvation and mid-flight reset, and random traffic against a timestamp model.
module tb_regfile_wb_arbiter;
    localparam int LIMIT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wen;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [31:0] pending_mask;

    regfile_wb_arbiter_if #(.DATA_W(32)) ex_if ();
    regfile_wb_arbiter_if #(.DATA_W(32)) mem_if ();

    regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT), .DATA_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .ex           (ex_if),
        .mem          (mem_if),
        .wen          (wen),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .pending_mask (pending_mask)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit ev, input logic [4:0] ea, input logic [31:0] ed,
                         input bit mv, input logic [4:0] ma, input logic [31:0] md);
        reset        = r;
        ex_if.valid  = ev;
        ex_if.addr   = ea;
        ex_if.data   = ed;
        mem_if.valid = mv;
        mem_if.addr  = ma;
        mem_if.data  = md;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 drive(1, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          rst;
        bit          ev;
        logic [4:0]  ea;
        logic [31:0] ed;
        bit          mv;
        logic [4:0]  ma;
        logic [31:0] md;
        bit          chk;
        bit          exr;
        bit          mr;
        bit          wen;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] mask;
    } vec_t;

    vec_t tbl[18];

    // ---------------- reference model ----------------
    typedef struct {
        bit          v;
        logic [4:0]  a;
        logic [31:0] d;
        int          t;
    } mslot_t;

    mslot_t      ms[2];
    int          mcnt;
    bit          mwen;
    logic [4:0]  mwa;
    logic [31:0] mwd;
    int          tick;

    function automatic void m_reset();
        for (int i = 0; i < 2; i++) ms[i] = '{0, 5'd0, 32'd0, 0};
        mcnt = 0;
        mwen = 0;
        mwa  = 5'd0;
        mwd  = 32'd0;
    endfunction

    // older entry (smaller load time; tie -> memory side) wins on equal address
    function automatic void m_grant(output bit g0, output bit g1);
        g0 = 0;
        g1 = 0;
        if (ms[0].v && ms[1].v) begin
            if (ms[0].a == ms[1].a) begin
                if (ms[0].t < ms[1].t) g0 = 1;
                else g1 = 1;
            end else if (mcnt >= LIMIT) g1 = 1;
            else g0 = 1;
        end else if (ms[0].v) g0 = 1;
        else if (ms[1].v) g1 = 1;
    endfunction

    function automatic logic [31:0] m_mask();
        logic [31:0] m = 32'd0;
        for (int r = 1; r < 32; r++)
            if ((ms[0].v && ms[0].a == r) || (ms[1].v && ms[1].a == r) || (mwen && mwa == r))
                m[r] = 1'b1;
        return m;
    endfunction

    function automatic void m_step(input bit ev, input logic [4:0] ea, input logic [31:0] ed,
                                   input bit mv, input logic [4:0] ma, input logic [31:0] md,
                                   input bit g0, input bit g1);
        bit er = !ms[0].v || g0;
        bit mr = !ms[1].v || g1;
        if (g0) begin
            mwen = ms[0].a != 0; mwa = ms[0].a; mwd = ms[0].d;
        end else if (g1) begin
            mwen = ms[1].a != 0; mwa = ms[1].a; mwd = ms[1].d;
        end else mwen = 0;
        if (ms[1].v && !g1) mcnt = (mcnt < LIMIT) ? mcnt + 1 : LIMIT;
        else mcnt = 0;
        if (g0) ms[0].v = 0;
        if (g1) ms[1].v = 0;
        if (ev && er) ms[0] = '{1, ea, ed, tick};
        if (mv && mr) ms[1] = '{1, ma, md, tick};
        tick++;
    endfunction

    function automatic logic [4:0] pick_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 3));
    endfunction

    initial begin
        logic [4:0] wr[$];
        logic [4:0] exp_order[6];
        int mr_low, na, stale;
        bit exr, mrd, g0, g1, er, mr, x0, x1;

        drive(0, 0, 0, 0, 0, 0, 0);

        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0};
        tbl[3]  = '{0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0};
        tbl[4]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 32'h20};
        tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 5, 32'hDEADBEEF, 32'h20};
        tbl[6]  = '{0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 1, 1, 0, 5, 32'hDEADBEEF, 0};
        tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 5, 32'hDEADBEEF, 0};
        tbl[8]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 32'hFFFFFFFF, 0};
        tbl[9]  = '{0, 0, 0, 0, 1, 7, 32'h11, 1, 1, 1, 0, 0, 32'hFFFFFFFF, 0};
        tbl[10] = '{0, 1, 7, 32'h22, 0, 0, 0, 1, 1, 1, 0, 0, 32'hFFFFFFFF, 32'h80};
        tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 7, 32'h11, 32'h80};
        tbl[12] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 7, 32'h22, 32'h80};
        tbl[13] = '{0, 1, 7, 32'h22, 1, 7, 32'h11, 1, 1, 1, 0, 7, 32'h22, 0};
        tbl[14] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 7, 32'h22, 32'h80};
        tbl[15] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 7, 32'h11, 32'h80};
        tbl[16] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 7, 32'h22, 32'h80};
        tbl[17] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 7, 32'h22, 0};

        for (int i = 0; i < 18; i++) begin
            @(posedge clk);
            #1 drive(tbl[i].rst, tbl[i].ev, tbl[i].ea, tbl[i].ed,
                     tbl[i].mv, tbl[i].ma, tbl[i].md);
            @(negedge clk);
            if (tbl[i].chk) begin
                chk($sformatf("row%0d ex_ready", i), 32'(ex_if.ready), 32'(tbl[i].exr));
                chk($sformatf("row%0d mem_ready", i), 32'(mem_if.ready), 32'(tbl[i].mr));
                chk($sformatf("row%0d wen", i), 32'(wen), 32'(tbl[i].wen));
                chk($sformatf("row%0d write_addr", i), 32'(write_addr), 32'(tbl[i].wa));
                chk($sformatf("row%0d write_data", i), write_data, tbl[i].wd);
                chk($sformatf("row%0d pending_mask", i), pending_mask, tbl[i].mask);
            end
        end

        // ---- starvation: ex streams r1..r5, mem r9 must win the 4th grant ----
        do_reset();
        drive(0, 1, 1, 32'd101, 1, 9, 32'h99);
        mr_low = 0;
        na = 1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (wen) wr.push_back(write_addr);
            if (!mem_if.ready) mr_low++;
            exr = ex_if.ready;
            mrd = mem_if.ready;
            @(posedge clk);
            #1;
            if (ex_if.valid && exr) begin
                na++;
                if (na > 5) ex_if.valid = 0;
                else begin
                    ex_if.addr = 5'(na);
                    ex_if.data = 32'(100 + na);
                end
            end
            if (mem_if.valid && mrd) mem_if.valid = 0;
        end
        exp_order = '{5'd1, 5'd2, 5'd3, 5'd9, 5'd4, 5'd5};
        chk("starve write count", 32'(wr.size()), 32'd6);
        for (int k = 0; k < 6; k++)
            if (k < wr.size()) chk($sformatf("starve order%0d", k), 32'(wr[k]), 32'(exp_order[k]));
        chk("starve mem_ready low cycles", 32'(mr_low), 32'd3);

        // ---- reset with both slots full and a write in the output stage ----
        do_reset();
        drive(0, 1, 3, 32'h33, 1, 4, 32'h44);
        @(posedge clk);
        #1 drive(0, 1, 6, 32'h66, 0, 0, 0);
        @(posedge clk);
        #1 drive(1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("midrst pre wen", 32'(wen), 32'd1);
        chk("midrst pre mask", pending_mask, 32'h58);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst wen", 32'(wen), 32'd0);
        chk("midrst mask", pending_mask, 32'd0);
        chk("midrst ex_ready", 32'(ex_if.ready), 32'd1);
        chk("midrst mem_ready", 32'(mem_if.ready), 32'd1);
        stale = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (wen) stale++;
        end
        chk("midrst stale writes", 32'(stale), 32'd0);

        // ---- random traffic against the model ----
        do_reset();
        m_reset();
        tick = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            m_grant(g0, g1);
            er = !ms[0].v || g0;
            mr = !ms[1].v || g1;
            chk("rnd ex_ready", 32'(ex_if.ready), 32'(er));
            chk("rnd mem_ready", 32'(mem_if.ready), 32'(mr));
            chk("rnd wen", 32'(wen), 32'(mwen));
            chk("rnd write_addr", 32'(write_addr), 32'(mwa));
            chk("rnd write_data", write_data, mwd);
            chk("rnd pending_mask", pending_mask, m_mask());
            x0 = ex_if.valid && er;
            x1 = mem_if.valid && mr;
            if (reset) m_reset();
            else m_step(ex_if.valid, ex_if.addr, ex_if.data,
                        mem_if.valid, mem_if.addr, mem_if.data, g0, g1);
            @(posedge clk);
            #1;
            if ($urandom_range(0, 199) == 0) begin
                drive(1, 0, 0, 0, 0, 0, 0);
            end else begin
                reset = 1'b0;
                if (!ex_if.valid || x0) begin
                    ex_if.valid = ($urandom_range(0, 3) != 0);
                    ex_if.addr  = pick_addr();
                    ex_if.data  = $urandom;
                end
                if (!mem_if.valid || x1) begin
                    mem_if.valid = ($urandom_range(0, 3) != 0);
                    mem_if.addr  = pick_addr();
                    mem_if.data  = $urandom;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
